// File: rtl/whac_pkg.sv
// Shared hole-state type and edge-detection mode constants for the hit judge.
package whac_pkg;

  typedef enum logic {
    Idle,
    Up
  } hole_state_e;

  localparam int unsigned EDGE_TOGGLE = 0;
  localparam int unsigned EDGE_RISE   = 1;

endpackage

// File: rtl/mole_timer.sv
// One hole: IDLE/UP state, lifetime countdown, and spawn/strike/expiry resolution.
module mole_timer
  import whac_pkg::*;
#(
  parameter int unsigned LIFE_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              spawn_i,
  input  logic [LIFE_W-1:0] life_i,
  input  logic              strike_i,
  output logic              up_o,
  output logic              up_next_o,
  output logic              hit_o,
  output logic              expire_o
);

  hole_state_e       state_q, state_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic              last_cycle;

  assign last_cycle = (life_q <= LIFE_W'(1));

  // Strike is judged on the current state; a same-cycle spawn still leaves the hole up.
  always_comb begin
    state_d  = state_q;
    life_d   = life_q;
    hit_o    = 1'b0;
    expire_o = 1'b0;
    if (!enable_i) begin
      state_d = Idle;
      life_d  = '0;
    end else begin
      hit_o = strike_i && (state_q == Up);
      if (spawn_i) begin
        state_d = Up;
        life_d  = (life_i == '0) ? LIFE_W'(1) : life_i;
      end else if (hit_o) begin
        state_d = Idle;
        life_d  = '0;
      end else if (state_q == Up) begin
        if (last_cycle) begin
          state_d  = Idle;
          life_d   = '0;
          expire_o = 1'b1;
        end else begin
          life_d = life_q - LIFE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      life_q  <= '0;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
    end
  end

  assign up_o      = (state_q == Up);
  assign up_next_o = (state_d == Up);

endmodule

// File: rtl/hit_judge.sv
// Whac-a-mole judge: synchronises switches, resolves strikes per hole, and keeps
// miss lockout, streak and best-streak bookkeeping.
module hit_judge
  import whac_pkg::*;
#(
  parameter int unsigned NUM_HOLES      = 18,
  parameter int unsigned LIFE_W         = 24,
  parameter int unsigned EDGE_MODE      = 0,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned STREAK_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_in_progress_i,
  input  logic [NUM_HOLES-1:0] spawn_i,
  input  logic [LIFE_W-1:0]    mole_life_i,
  input  logic [NUM_HOLES-1:0] switches_i,
  output logic [NUM_HOLES-1:0] leds_o,
  output logic                 hit_o,
  output logic                 full_clear_hit_o,
  output logic                 miss_o,
  output logic                 expired_o,
  output logic [STREAK_W-1:0]  streak_o,
  output logic [STREAK_W-1:0]  best_streak_o,
  output logic                 locked_o
);

  localparam int unsigned CntW  = $clog2(NUM_HOLES + 1);
  localparam int unsigned SumW  = ((STREAK_W > CntW) ? STREAK_W : CntW) + 1;
  localparam int unsigned LockW = (LOCKOUT_CYCLES == 0) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  logic [NUM_HOLES-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_HOLES-1:0] strike_raw, strike_eff;
  logic [NUM_HOLES-1:0] up, up_next, hit_vec, expire_vec;
  logic [LockW-1:0]     lockout_q, lockout_d;
  logic [STREAK_W-1:0]  streak_q, streak_d, best_q, best_d;
  logic [CntW-1:0]      hit_cnt;
  logic [SumW-1:0]      sum;
  logic                 lock_active, hit_ev, miss_ev, exp_ev, full_clear_ev;
  logic                 hit_q, full_clear_q, miss_q, expired_q;

  // Edge history keeps running even when idle or locked so no phantom strikes appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= switches_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign strike_raw  = (EDGE_MODE == EDGE_RISE) ? (sync2_q & ~hist_q) : (sync2_q ^ hist_q);
  assign lock_active = (lockout_q != '0);
  assign strike_eff  = (game_in_progress_i && !lock_active) ? strike_raw : '0;

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
    mole_timer #(
      .LIFE_W(LIFE_W)
    ) u_mole_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (game_in_progress_i),
      .spawn_i  (spawn_i[g]),
      .life_i   (mole_life_i),
      .strike_i (strike_eff[g]),
      .up_o     (up[g]),
      .up_next_o(up_next[g]),
      .hit_o    (hit_vec[g]),
      .expire_o (expire_vec[g])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      hit_cnt = hit_cnt + CntW'(hit_vec[i]);
    end
  end

  assign miss_ev       = |(strike_eff & ~up);
  assign hit_ev        = |hit_vec;
  assign exp_ev        = |expire_vec;
  assign full_clear_ev = hit_ev && !(|up_next);
  assign sum           = SumW'(streak_q) + SumW'(hit_cnt);

  always_comb begin
    lockout_d = lockout_q;
    streak_d  = streak_q;
    if (!game_in_progress_i) begin
      lockout_d = '0;
      streak_d  = '0;
    end else begin
      if (miss_ev) begin
        lockout_d = LockW'(LOCKOUT_CYCLES);
      end else if (lock_active) begin
        lockout_d = lockout_q - LockW'(1);
      end
      // A miss or expiry in the same cycle as hits still breaks the streak.
      if (miss_ev || exp_ev) begin
        streak_d = '0;
      end else if (|sum[SumW-1:STREAK_W]) begin
        streak_d = '1;
      end else begin
        streak_d = sum[STREAK_W-1:0];
      end
    end
    best_d = (streak_d > best_q) ? streak_d : best_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockout_q    <= '0;
      streak_q     <= '0;
      best_q       <= '0;
      hit_q        <= 1'b0;
      full_clear_q <= 1'b0;
      miss_q       <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      lockout_q    <= lockout_d;
      streak_q     <= streak_d;
      best_q       <= best_d;
      hit_q        <= hit_ev;
      full_clear_q <= full_clear_ev;
      miss_q       <= miss_ev;
      expired_q    <= exp_ev;
    end
  end

  assign leds_o           = up;
  assign hit_o            = hit_q;
  assign full_clear_hit_o = full_clear_q;
  assign miss_o           = miss_q;
  assign expired_o        = expired_q;
  assign streak_o         = streak_q;
  assign best_streak_o    = best_q;
  assign locked_o         = lock_active;

endmodule
